// File: rtl/conv_store_pkg.sv
// ---------------------------------------------------------------------------
// conv_store_pkg
//   Shared definitions for the convolution tile-store path:
//     state_t    - sequencer states of conv_store_ddr_packer
//     MODE_HALF  - two FIFO words per DDR beat, low half of each word kept
//     MODE_FULL  - one FIFO word per DDR beat
//     SKID_DEPTH - entries in the beat skid buffer in front of the data channel
// ---------------------------------------------------------------------------
package conv_store_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    NEXT,
    DONE
  } state_t;

  localparam logic MODE_HALF = 1'b0;
  localparam logic MODE_FULL = 1'b1;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/store_skid_buf.sv
// ---------------------------------------------------------------------------
// store_skid_buf
//   Two-entry FIFO decoupling the packed-beat producer from the DDR write-data
//   channel. Valid/ready handshake on both sides; `level` exposes occupancy
//   so the producer can reserve space for reads already in flight.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    producer handshake, in_data the beat
//   out_valid/out_ready  consumer handshake, out_data the head beat
//   level                entries currently held (0..2)
// ---------------------------------------------------------------------------
module store_skid_buf
  import conv_store_pkg::*;
#(
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    level
);

  logic [DW-1:0] mem [SKID_DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  assign in_ready  = (count != 2'(SKID_DEPTH));
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign level     = count;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // NOTE: the storage is reset along with the pointers because out_data
  // drives wdata directly and must read as zero straight out of reset; a
  // deep memory would normally be left unreset and masked instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/conv_store_ddr_packer.sv
// ---------------------------------------------------------------------------
// conv_store_ddr_packer
//   Drains the SA_ROWS*SA_COLS systolic-array output FIFOs into DDR, one
//   write burst per FIFO. For each FIFO f (row-major, column fastest) it
//   issues a command at base_adr + f*fifo_stride with length `beats`, then
//   reads the FIFO and streams beats on the write-data channel. In half mode
//   two FIFO words are packed into one beat (low halves only).
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   start                    one-cycle tile-store request (accepted in IDLE)
//   base_adr, fifo_stride    region of FIFO 0 and spacing between regions
//   beats, mode              beats per FIFO and packing mode, sampled at start
//   fifo_empty/fifo_rd       per-FIFO empty flags / one-hot read strobes
//   fifo_data                shared read data, one cycle after fifo_rd
//   cmd_valid/ready/adr/len  DDR write-command channel
//   wdata_valid/ready/wdata  DDR write-data channel
//   done                     one-cycle pulse when the tile is stored
// ---------------------------------------------------------------------------
module conv_store_ddr_packer
  import conv_store_pkg::*;
#(
  parameter int SA_ROWS = 4,
  parameter int SA_COLS = 3,
  parameter int DW      = 512,
  parameter int LEN_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [31:0]                base_adr,
  input  logic [31:0]                fifo_stride,
  input  logic [LEN_W-1:0]           beats,
  input  logic                       mode,
  input  logic [SA_ROWS*SA_COLS-1:0] fifo_empty,
  output logic [SA_ROWS*SA_COLS-1:0] fifo_rd,
  input  logic [DW-1:0]              fifo_data,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [31:0]                cmd_adr,
  output logic [LEN_W-1:0]           cmd_len,
  output logic                       wdata_valid,
  input  logic                       wdata_ready,
  output logic [DW-1:0]              wdata,
  output logic                       done
);

  localparam int NF = SA_ROWS * SA_COLS;
  localparam int FW = (NF > 1) ? $clog2(NF) : 1;

  state_t          state_q, state_d;
  logic [FW-1:0]   f_q;          // FIFO currently being drained
  logic [31:0]     adr_q;        // command address of FIFO f_q
  logic [31:0]     stride_q;
  logic [LEN_W-1:0] len_q;
  logic            mode_q;
  logic [LEN_W:0]  rd_cnt_q;     // reads issued to FIFO f_q
  logic [LEN_W-1:0] beat_cnt_q;  // beats transferred for FIFO f_q
  logic            rd_phase_q;   // half mode: next read is the second of a pair
  logic            rd_q;         // a read was issued last cycle, data is on fifo_data
  logic            rd_beat_q;    // ... and that read completes a beat
  logic            half_q;       // half mode: lo_q holds the first word of a pair
  logic [DW/2-1:0] lo_q;

  logic            rd_en;
  logic            rd_beat;
  logic [LEN_W:0]  rd_total;
  logic [2:0]      need;
  logic [2:0]      room;
  logic            beat_xfer;
  logic            last_beat;
  logic            skid_in_valid;
  logic            skid_in_ready;
  logic [DW-1:0]   skid_in_data;
  logic [1:0]      skid_level;

  assign rd_total  = (mode_q == MODE_FULL) ? {1'b0, len_q} : {len_q, 1'b0};
  assign beat_xfer = wdata_valid && wdata_ready;
  assign last_beat = beat_xfer && (beat_cnt_q == len_q - LEN_W'(1));

  // Read data cannot be back-pressured, so a read may only issue if the beat
  // it eventually completes still fits in the skid buffer: current level plus
  // the beat already in flight, minus the beat leaving this cycle, plus this
  // one must not exceed two. Counting the departing beat keeps full-mode
  // throughput at one beat per cycle.
  assign rd_beat = (mode_q == MODE_FULL) || rd_phase_q;
  assign need    = {1'b0, skid_level} + {2'b0, rd_q && rd_beat_q} + {2'b0, rd_beat};
  assign room    = 3'(SKID_DEPTH) + {2'b0, beat_xfer};

  assign rd_en = (state_q == DATA) && !fifo_empty[f_q] &&
                 (rd_cnt_q != rd_total) && (need <= room);

  assign fifo_rd = rd_en ? (NF'(1) << f_q) : '0;

  // In half mode the second word of a pair supplies the upper half of the beat.
  assign skid_in_valid = rd_q && ((mode_q == MODE_FULL) || half_q);
  assign skid_in_data  = (mode_q == MODE_FULL) ? fifo_data
                                               : {fifo_data[DW/2-1:0], lo_q};

  store_skid_buf #(
    .DW (DW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .in_data   (skid_in_data),
    .out_valid (wdata_valid),
    .out_ready (wdata_ready),
    .out_data  (wdata),
    .level     (skid_level)
  );

  skid_no_overflow: assert property (
    @(posedge clk) disable iff (reset) skid_in_valid |-> skid_in_ready
  );

  assign cmd_adr = adr_q;
  assign cmd_len = len_q;

  // NOTE: every output of this block gets a default before the case, so no
  // path through it leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cmd_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (beats == '0) ? DONE : CMD;
        end
      end
      CMD: begin
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (last_beat) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        state_d = (f_q == FW'(NF - 1)) ? DONE : CMD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; a blocking assignment here would let later
  // statements see the updated value and change the hardware described.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      f_q        <= '0;
      adr_q      <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      mode_q     <= MODE_HALF;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      rd_phase_q <= 1'b0;
      rd_q       <= 1'b0;
      rd_beat_q  <= 1'b0;
      half_q     <= 1'b0;
      lo_q       <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_en;
      rd_beat_q <= rd_beat;

      if (rd_en) begin
        rd_cnt_q   <= rd_cnt_q + (LEN_W + 1)'(1);
        rd_phase_q <= (mode_q == MODE_HALF) && !rd_phase_q;
      end

      if (rd_q && (mode_q == MODE_HALF)) begin
        half_q <= !half_q;
        if (!half_q) begin
          lo_q <= fifo_data[DW/2-1:0];
        end
      end

      if (beat_xfer) begin
        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
      end

      unique case (state_q)
        IDLE: begin
          if (start) begin
            adr_q    <= base_adr;
            stride_q <= fifo_stride;
            len_q    <= beats;
            mode_q   <= mode;
            f_q      <= '0;
          end
        end
        CMD: begin
          if (cmd_ready) begin
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            rd_phase_q <= 1'b0;
          end
        end
        NEXT: begin
          // Accumulating the stride gives base + f*stride modulo 2^32.
          if (f_q != FW'(NF - 1)) begin
            f_q   <= f_q + FW'(1);
            adr_q <= adr_q + stride_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_store_ddr_packer.sv
module tb_conv_store_ddr_packer;
  import conv_store_pkg::*;

  localparam int SA_ROWS = 4;
  localparam int SA_COLS = 3;
  localparam int NF      = SA_ROWS * SA_COLS;
  localparam int DW      = 512;
  localparam int LEN_W   = 16;
  localparam int BUDGET  = 20000;

  logic             clk;
  logic             reset;
  logic             start;
  logic [31:0]      base_adr;
  logic [31:0]      fifo_stride;
  logic [LEN_W-1:0] beats;
  logic             mode;
  logic [NF-1:0]    fifo_empty;
  logic [NF-1:0]    fifo_rd;
  logic [DW-1:0]    fifo_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_adr;
  logic [LEN_W-1:0] cmd_len;
  logic             wdata_valid;
  logic             wdata_ready;
  logic [DW-1:0]    wdata;
  logic             done;

  conv_store_ddr_packer #(
    .SA_ROWS (SA_ROWS),
    .SA_COLS (SA_COLS),
    .DW      (DW),
    .LEN_W   (LEN_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_adr    (base_adr),
    .fifo_stride (fifo_stride),
    .beats       (beats),
    .mode        (mode),
    .fifo_empty  (fifo_empty),
    .fifo_rd     (fifo_rd),
    .fifo_data   (fifo_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_adr     (cmd_adr),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    int          beats;
    logic [31:0] base;
    logic [31:0] stride;
    bit          cmd_stall;
    bit          wr_toggle;
    bit          empty5;
    bit          chk_rate;
    int          exp_cmds;
    int          exp_reads;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]      exp_adr_q[$];
  logic [LEN_W-1:0] exp_len_q[$];
  logic [DW-1:0]    exp_beat_q[$];

  int          rd_count[NF];
  bit          rd_pend;
  int          rd_pf;
  int          cmd_stall_cnt;
  int          empty5_cnt;
  bit          empty5_done;
  bit          cur_cmd_stall, cur_wr_toggle, cur_empty5;
  int          cur_beats;
  int          tile_total;
  int          done_cnt;
  int          cmds_seen;
  bit          cmd_stalled, wd_stalled;
  logic [31:0] cmd_adr_prev;
  logic [LEN_W-1:0] cmd_len_prev;
  logic [DW-1:0] wd_prev;
  bit          chk_zero;
  int          gcyc;
  int          last_xfer_cyc;
  int          gap_err;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO f, k-th word: low 32 bits k+1, FIFO index above it, upper half all
  // ones so that half-mode packing must discard it.
  function automatic logic [DW-1:0] word(input int f, input int k);
    logic [DW-1:0] w;
    w = '1;
    w[DW/2-1:0] = '0;
    w[31:0]  = 32'(k + 1);
    w[47:32] = 16'(f);
    return w;
  endfunction

  function automatic logic [DW-1:0] exp_beat(input int f, input int b, input logic m);
    logic [DW-1:0] w0, w1;
    if (m == MODE_FULL) return word(f, b);
    w0 = word(f, 2 * b);
    w1 = word(f, 2 * b + 1);
    return {w1[DW/2-1:0], w0[DW/2-1:0]};
  endfunction

  // One clock cycle: monitor at the falling edge, update the FIFO model and
  // the ready/empty drivers just after the rising edge.
  task automatic step();
    @(negedge clk);
    gcyc++;
    if (chk_zero) begin
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_cmd_adr", cmd_adr, 0);
      check("rst_cmd_len", cmd_len, 0);
      check("rst_wdata_valid", wdata_valid, 0);
      check("rst_wdata", wdata, 0);
      check("rst_fifo_rd", fifo_rd, 0);
      check("rst_done", done, 0);
    end

    rd_pend = 1'b0;
    if (fifo_rd !== '0) begin
      check("rd_onehot", $onehot(fifo_rd), 1);
      check("rd_while_empty", |(fifo_rd & fifo_empty), 0);
      for (int i = 0; i < NF; i++) if (fifo_rd[i]) rd_pf = i;
      rd_pend = 1'b1;
    end

    if (cmd_stalled) begin
      check("cmd_hold_valid", cmd_valid, 1);
      check("cmd_hold_adr", cmd_adr, cmd_adr_prev);
      check("cmd_hold_len", cmd_len, cmd_len_prev);
    end
    if (cmd_valid === 1'b1 && cmd_ready) begin
      if (exp_adr_q.size() == 0) begin
        check("cmd_unexpected", 1, 0);
      end else begin
        check("cmd_order", exp_beat_q.size(), (NF - cmds_seen) * cur_beats);
        check("cmd_adr", cmd_adr, exp_adr_q.pop_front());
        check("cmd_len", cmd_len, exp_len_q.pop_front());
        cmds_seen++;
      end
      cmd_stall_cnt = cur_cmd_stall ? 40 : 0;
    end
    cmd_stalled  = (cmd_valid === 1'b1) && !cmd_ready;
    cmd_adr_prev = cmd_adr;
    cmd_len_prev = cmd_len;

    if (wd_stalled) begin
      check("wdata_hold_valid", wdata_valid, 1);
      check("wdata_hold_data", wdata, wd_prev);
    end
    if (wdata_valid === 1'b1 && wdata_ready) begin
      if (exp_beat_q.size() == 0) begin
        check("beat_unexpected", 1, 0);
      end else begin
        if (((tile_total - exp_beat_q.size()) % cur_beats) != 0 &&
            gcyc != last_xfer_cyc + 1) gap_err++;
        last_xfer_cyc = gcyc;
        check("beat_data", wdata, exp_beat_q.pop_front());
      end
    end
    wd_stalled = (wdata_valid === 1'b1) && !wdata_ready;
    wd_prev    = wdata;

    if (done === 1'b1) done_cnt++;

    @(posedge clk);
    #1;
    if (rd_pend) begin
      fifo_data = word(rd_pf, rd_count[rd_pf]);
      rd_count[rd_pf]++;
    end
    if (cmd_stall_cnt > 0) begin
      cmd_ready = 1'b0;
      cmd_stall_cnt--;
    end else begin
      cmd_ready = 1'b1;
    end
    wdata_ready = cur_wr_toggle ? ~wdata_ready : 1'b1;
    if (cur_empty5 && !empty5_done && rd_count[5] >= 2) begin
      empty5_cnt  = 20;
      empty5_done = 1'b1;
    end
    fifo_empty = '0;
    if (empty5_cnt > 0) begin
      fifo_empty[5] = 1'b1;
      empty5_cnt--;
    end
  endtask

  task automatic launch_tile(input vec_t v);
    exp_adr_q.delete();
    exp_len_q.delete();
    exp_beat_q.delete();
    if (v.beats != 0) begin
      for (int f = 0; f < NF; f++) begin
        exp_adr_q.push_back(v.base + 32'(f) * v.stride);
        exp_len_q.push_back(LEN_W'(v.beats));
        for (int b = 0; b < v.beats; b++) exp_beat_q.push_back(exp_beat(f, b, v.mode));
      end
    end
    for (int f = 0; f < NF; f++) rd_count[f] = 0;
    cur_cmd_stall = v.cmd_stall;
    cur_wr_toggle = v.wr_toggle;
    cur_empty5    = v.empty5;
    cur_beats     = (v.beats == 0) ? 1 : v.beats;
    tile_total    = NF * v.beats;
    empty5_cnt    = 0;
    empty5_done   = 1'b0;
    done_cnt      = 0;
    cmds_seen     = 0;
    gap_err       = 0;
    last_xfer_cyc = 0;
    base_adr      = v.base;
    fifo_stride   = v.stride;
    beats         = LEN_W'(v.beats);
    mode          = v.mode;
    start         = 1'b1;
    step();
    start         = 1'b0;
  endtask

  task automatic finish_tile(input vec_t v);
    int cyc;
    int bad;
    cyc = 0;
    while (done_cnt == 0 && cyc < BUDGET) begin
      step();
      cyc++;
    end
    if (cyc >= BUDGET) check("tile_timeout", cyc, 0);
    repeat (3) step();
    check("done_count", done_cnt, 1);
    check("cmd_count", cmds_seen, v.exp_cmds);
    check("cmds_left", exp_adr_q.size(), 0);
    check("beats_left", exp_beat_q.size(), 0);
    bad = 0;
    for (int f = 0; f < NF; f++) if (rd_count[f] != v.exp_reads) bad++;
    check("reads_per_fifo", bad, 0);
    if (v.chk_rate) check("full_rate_gaps", gap_err, 0);
  endtask

  vec_t vecs[6];
  vec_t v;
  int   cyc;

  initial begin
    //           mode       beats base          stride        stl tgl e5 rate cmds reads
    vecs[0] = '{MODE_FULL, 4, 32'h0000_1000, 32'h0000_0400, 0,  0,  0, 1,   12,  4};
    vecs[1] = '{MODE_HALF, 2, 32'h0002_0000, 32'h0000_0100, 0,  0,  0, 0,   12,  4};
    vecs[2] = '{MODE_FULL, 3, 32'hFFFF_F000, 32'h0000_0800, 1,  1,  0, 0,   12,  3};
    vecs[3] = '{MODE_HALF, 3, 32'h8000_0000, 32'h0000_0040, 1,  1,  0, 0,   12,  6};
    vecs[4] = '{MODE_FULL, 5, 32'h0000_0000, 32'h0000_1000, 0,  0,  1, 0,   12,  5};
    vecs[5] = '{MODE_HALF, 1, 32'h0000_0010, 32'h0000_0020, 0,  1,  0, 0,   12,  2};

    reset       = 1'b1;
    start       = 1'b0;
    base_adr    = '0;
    fifo_stride = '0;
    beats       = '0;
    mode        = MODE_FULL;
    fifo_empty  = '0;
    fifo_data   = '0;
    cmd_ready   = 1'b1;
    wdata_ready = 1'b1;
    gcyc        = 0;
    cur_beats   = 1;
    chk_zero    = 1'b0;
    repeat (3) step();
    reset    = 1'b0;
    chk_zero = 1'b1;
    step();
    chk_zero = 1'b0;

    // Explicit first half-packed beat: {word 2 low half, word 1 low half}.
    v = vecs[1];
    check("half_beat0_model", exp_beat(0, 0, MODE_HALF),
          {{(DW/2-48){1'b0}}, 16'd0, 32'd2, {(DW/2-48){1'b0}}, 16'd0, 32'd1});

    foreach (vecs[i]) begin
      launch_tile(vecs[i]);
      finish_tile(vecs[i]);
    end

    // Zero-beat tile: done the cycle after start, no command.
    v = '{MODE_FULL, 0, 32'h0000_4000, 32'h0000_0100, 0, 0, 0, 0, 0, 0};
    launch_tile(v);
    step();
    check("zero_beats_done_next", done_cnt, 1);
    finish_tile(v);

    // Reset in the middle of a burst, then a clean tile with a start pulse
    // issued mid-tile that must be ignored.
    launch_tile(vecs[0]);
    cyc = 0;
    while (exp_beat_q.size() > NF * 4 - 2 && cyc < BUDGET) begin
      step();
      cyc++;
    end
    if (cyc >= BUDGET) check("reach_data_timeout", cyc, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_adr_q.delete();
    exp_len_q.delete();
    exp_beat_q.delete();
    cmd_stalled = 1'b0;
    wd_stalled  = 1'b0;
    chk_zero    = 1'b1;
    step();
    chk_zero    = 1'b0;
    repeat (4) step();
    check("no_done_after_reset", done_cnt, 0);

    launch_tile(vecs[0]);
    repeat (30) step();
    base_adr = 32'hDEAD_0000;
    beats    = LEN_W'(7);
    start    = 1'b1;
    step();
    start    = 1'b0;
    finish_tile(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
